lsu_store_buffer: RTL and testbench

Load/store unit between the core's memory stage and the word-addressed data memory. It converts byte, halfword and word accesses into whole-word DMEM operations. Stores go into a small posted write buffer that drains with read-modify-write on idle cycles. Loads return aligned, sign- or zero-extended data one cycle after acceptance.

---
 rtl/lsu_store_buffer.sv | 135 +++++++++++++
 tb/tb_lsu_store_buffer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/lsu_store_buffer.sv
// rtl/lsu_store_buffer.sv - LSU with posted store buffer draining by read-modify-write
// Loads bypass the buffer unless an older store targets the same word, in which case they stall.
module lsu_store_buffer #(
  parameter int Width     = 32,
  parameter int Depth     = 4,
  parameter int AddrWidth = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [Width-1:0] req_addr,
  input  logic [Width-1:0] req_wdata,
  output logic             resp_valid,
  output logic [Width-1:0] resp_rdata,
  output logic             misalign,
  output logic             drained,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [Width-1:0] address,
  output logic [Width-1:0] WriteData,
  input  logic [Width-1:0] ReadData
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = PtrW + 1;
  localparam int Lanes = Width / 8;

  logic [AddrWidth-1:0] sb_index [Depth];
  logic [Width-1:0]     sb_data  [Depth];
  logic [Lanes-1:0]     sb_mask  [Depth];
  logic [PtrW-1:0]      head, tail;
  logic [CntW-1:0]      count;

  logic [1:0]           lane;
  logic [AddrWidth-1:0] idx;
  logic                 misal, full, hazard;
  logic                 load_acc, store_acc, drain;
  logic [AddrWidth-1:0] mem_idx;
  logic [Width-1:0]     wmask, shifted, load_ext, enq_data;
  logic [Lanes-1:0]     enq_mask;
  logic                 unused_addr;

  assign lane        = req_addr[1:0];
  assign idx         = req_addr[AddrWidth+1:2];
  assign unused_addr = ^req_addr[Width-1:AddrWidth+2];
  assign full        = (count == CntW'(Depth));
  assign drained     = (count == '0);

  always_comb begin
    misal = 1'b0;
    case (req_size)
      2'b01:   misal = lane[0];
      2'b10:   misal = (lane != 2'b00);
      2'b11:   misal = 1'b1;
      default: misal = 1'b0;
    endcase
  end

  // Only entries between head and head+count are live.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (CntW'(i) < count && sb_index[head + PtrW'(i)] == idx) hazard = 1'b1;
    end
  end

  always_comb begin
    req_ready = 1'b1;
    if (!misal) req_ready = req_we ? !full : (!full && !hazard);
  end

  assign load_acc  = req_valid && req_ready && !req_we && !misal;
  assign store_acc = req_valid && req_ready &&  req_we && !misal;
  assign drain     = !load_acc && (count != '0) &&
                     (!req_valid || full || (!req_we && !misal && hazard));

  assign mem_idx   = load_acc ? idx : sb_index[head];
  assign address   = {{(Width-AddrWidth){1'b0}}, mem_idx};
  assign MemRead   = !reset && (load_acc || drain);
  assign MemWrite  = !reset && drain;

  always_comb begin
    wmask = '0;
    for (int b = 0; b < Lanes; b++) wmask[8*b +: 8] = {8{sb_mask[head][b]}};
  end
  assign WriteData = (ReadData & ~wmask) | (sb_data[head] & wmask);

  assign shifted = ReadData >> {lane, 3'b000};
  always_comb begin
    case (req_size)
      2'b00:   load_ext = {{(Width-8){!req_unsigned && shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{(Width-16){!req_unsigned && shifted[15]}}, shifted[15:0]};
      default: load_ext = ReadData;
    endcase
  end

  assign enq_data = req_wdata << {lane, 3'b000};
  always_comb begin
    case (req_size)
      2'b00:   enq_mask = Lanes'(4'b0001) << lane;
      2'b01:   enq_mask = Lanes'(4'b0011) << lane;
      default: enq_mask = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      misalign   <= 1'b0;
    end else begin
      resp_valid <= load_acc;
      misalign   <= req_valid && misal;
      if (load_acc) resp_rdata <= load_ext;
      if (store_acc) begin
        sb_index[tail] <= idx;
        sb_data[tail]  <= enq_data;
        sb_mask[tail]  <= enq_mask;
        tail           <= tail + PtrW'(1);
      end
      if (drain) head <= head + PtrW'(1);
      case ({store_acc, drain})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_store_buffer.sv
// tb/tb_lsu_store_buffer.sv - directed bench for lsu_store_buffer with a 512-word DMEM model
// DMEM word i holds i after power-up.
module tb_lsu_store_buffer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, misalign, drained, MemRead, MemWrite;
  logic [31:0] resp_rdata, address, WriteData, ReadData;
  logic [31:0] mem [512];
  int          total = 0, bad = 0, st;

  always #5 clk = ~clk;

  lsu_store_buffer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .misalign(misalign), .drained(drained),
    .MemRead(MemRead), .MemWrite(MemWrite), .address(address),
    .WriteData(WriteData), .ReadData(ReadData)
  );

  initial for (int i = 0; i < 512; i++) mem[i] = i;
  assign ReadData = mem[address[8:0]];
  always @(posedge clk) if (MemWrite) mem[address[8:0]] <= WriteData;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = d;
  endtask

  task automatic wait_ready(output int stalls);
    stalls = 0;
    #1;
    while (!req_ready && stalls < 20) begin
      @(posedge clk); #1; stalls++;
    end
    @(posedge clk); #1;
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                       input int exp_stalls, input string tag);
    int s;
    drive(1'b1, sz, 1'b0, a, d);
    wait_ready(s);
    check(tag, s, exp_stalls);
  endtask

  task automatic load(input logic [1:0] sz, input logic u, input logic [31:0] a,
                      input logic [31:0] exp, input int exp_stalls, input string tag);
    int s;
    drive(1'b0, sz, u, a, '0);
    wait_ready(s);
    req_valid = 1'b0;
    check({tag, "_stall"}, s, exp_stalls);
    check({tag, "_valid"}, resp_valid, 1'b1);
    check(tag, resp_rdata, exp);
  endtask

  task automatic wait_drained(input string tag);
    int n = 0;
    req_valid = 1'b0;
    #1;
    while (!drained && n < 20) begin @(posedge clk); #1; n++; end
    check(tag, drained, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_memread", MemRead, 1'b0);
    check("rst_memwrite", MemWrite, 1'b0);
    check("rst_drained", drained, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_misalign", misalign, 1'b0);
    reset = 1'b0;

    // First load: accept-cycle DMEM port, then response
    drive(1'b0, 2'b10, 1'b0, 32'h0C, '0);
    #1;
    check("lw_ready", req_ready, 1'b1);
    check("lw_memread", MemRead, 1'b1);
    check("lw_address", address, 32'd3);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("lw_resp_valid", resp_valid, 1'b1);
    check("lw_rdata", resp_rdata, 32'h3);
    @(posedge clk); #1;
    check("lw_resp_once", resp_valid, 1'b0);

    // Byte store with RMW drain
    store(2'b00, 32'h05, 32'h80, 0, "sb_stall");
    req_valid = 1'b0;
    #1;
    check("sb_memwrite", MemWrite, 1'b1);
    check("sb_address", address, 32'd1);
    check("sb_wdata", WriteData, 32'h00008001);
    @(posedge clk); #1;
    check("sb_drained", drained, 1'b1);
    check("sb_mem1", mem[1], 32'h00008001);
    load(2'b00, 1'b0, 32'h05, 32'hFFFFFF80, 0, "lb");
    load(2'b00, 1'b1, 32'h05, 32'h00000080, 0, "lbu");
    store(2'b01, 32'h06, 32'hBEEF, 0, "sh_stall");
    req_valid = 1'b0;
    @(posedge clk); #1;
    load(2'b01, 1'b0, 32'h06, 32'hFFFFBEEF, 0, "lh");

    // Fill the buffer with req_valid held high
    for (int k = 0; k < 5; k++)
      store(2'b10, 32'h20 + 4 * k, 32'hA0 + k, (k == 4) ? 1 : 0, $sformatf("fill%0d_stall", k));
    wait_drained("fill_drained");
    for (int k = 0; k < 5; k++) check($sformatf("fill_mem%0d", 8 + k), mem[8 + k], 32'hA0 + k);

    // Hazard load waits for the matching entry to drain
    store(2'b10, 32'h40, 32'hDEADBEEF, 0, "hz_st_stall");
    load(2'b10, 1'b0, 32'h40, 32'hDEADBEEF, 1, "hz_lw");
    wait_drained("hz_drained");

    // Misaligned accesses with one store still buffered
    store(2'b10, 32'h50, 32'h11, 0, "ma_st_stall");
    drive(1'b0, 2'b10, 1'b0, 32'h06, '0);
    #1;
    check("ma_lw_ready", req_ready, 1'b1);
    check("ma_lw_memread", MemRead, 1'b0);
    check("ma_lw_memwrite", MemWrite, 1'b0);
    @(posedge clk); #1;
    check("ma_lw_pulse", misalign, 1'b1);
    drive(1'b0, 2'b01, 1'b0, 32'h03, '0);
    #1;
    check("ma_lh_memread", MemRead, 1'b0);
    @(posedge clk); #1;
    check("ma_lh_pulse", misalign, 1'b1);
    drive(1'b1, 2'b11, 1'b0, 32'h08, 32'h77);
    #1;
    check("ma_sz11_memwrite", MemWrite, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("ma_sz11_pulse", misalign, 1'b1);
    check("ma_resp_valid", resp_valid, 1'b0);
    check("ma_count_kept", drained, 1'b0);
    @(posedge clk); #1;
    check("ma_pulse_end", misalign, 1'b0);
    wait_drained("ma_drained");
    check("ma_mem20", mem[20], 32'h11);
    check("ma_mem2", mem[2], 32'h2);

    // Reset with three buffered stores discards them
    for (int k = 0; k < 3; k++)
      store(2'b10, 32'h60 + 4 * k, 32'h55 + k, 0, $sformatf("rs_st%0d_stall", k));
    reset = 1'b1; req_valid = 1'b0;
    #1;
    check("rs_memwrite_in_reset", MemWrite, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rs_drained", drained, 1'b1);
    check("rs_memwrite_after", MemWrite, 1'b0);
    @(posedge clk); #1;
    check("rs_mem24", mem[24], 32'd24);
    load(2'b10, 1'b0, 32'h60, 32'd24, 0, "rs_lw");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
